// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I pipeline front end.
package riscv_pkg;

    localparam int unsigned IMEM_BYTES_DEFAULT = 1024;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetch entries. Flush wins over push; a pop in the
// flush cycle is simply absorbed by the flush. When empty, head keeps
// showing the last entry that was presented.
module fetch_queue
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    fetch_entry_t mem [2];
    fetch_entry_t last_head;
    logic [1:0]   count;
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    assign do_push = push && !flush && (!full || do_pop);
    assign head    = empty ? last_head : mem[rd_ptr];

    // Storage, pointers and occupancy; also remembers the presented head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            last_head <= '0;
            count     <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
        end else begin
            last_head <= head;
            if (flush) begin
                count  <= '0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= push_data;
                    wr_ptr      <= ~wr_ptr;
                end
                if (do_pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                count <= count + 2'(do_push) - 2'(do_pop);
            end
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch initiator: owns the PC, drives the combinational
// instruction memory, buffers fetched words for decode and raises a
// sticky fault on misaligned redirects or out-of-range fetches.
module ifetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES   = IMEM_BYTES_DEFAULT,
    parameter int unsigned QUEUE_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fault,
    output logic [31:0] fault_pc
);

    if (QUEUE_DEPTH != 2) begin : g_bad_depth
        $error("ifetch_unit supports QUEUE_DEPTH=2 only");
    end

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fault_pc_q, fault_pc_d;
    logic         q_full, q_empty;
    logic         pop, push, range_err;
    fetch_entry_t head;

    assign imem_addr = pc_q;
    assign out_valid = !q_empty;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign fault     = (state_q == FAULT);
    assign fault_pc  = fault_pc_q;
    assign pop       = out_valid && out_ready;
    assign range_err = (state_q == FETCH) && (pc_q >= 32'(IMEM_BYTES));

    fetch_queue u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ('{pc: pc_q, instr: imem_instr}),
        .pop       (pop),
        .flush     (redirect_valid),
        .full      (q_full),
        .empty     (q_empty),
        .head      (head)
    );

    // PC, state and fault address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_VECTOR;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    // Redirect beats everything; otherwise fetch while there is room and the PC is in range.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        push       = 1'b0;
        if (redirect_valid) begin
            pc_d = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                state_d    = FAULT;
                fault_pc_d = redirect_pc;
            end else begin
                state_d = FETCH;
            end
        end else if (state_q == FETCH) begin
            if (range_err) begin
                state_d    = FAULT;
                fault_pc_d = pc_q;
            end else if (!q_full || pop) begin
                push = 1'b1;
                pc_d = pc_q + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit with a PC scoreboard.
module tb_ifetch_unit;
    import riscv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;
    logic [31:0] fault_pc;

    int          checks;
    int          failures;
    logic [31:0] exp_q[$];
    logic [31:0] exp;

    ifetch_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .IMEM_BYTES   (1024),
        .QUEUE_DEPTH  (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h4) return 32'h0010_0093;
        return 32'hA500_0000 ^ {a[15:0], a[15:0]};
    endfunction

    assign imem_instr = word_at(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 ||
            fault !== 1'b0 || fault_pc !== 32'h0 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset: got valid=%b pc=%h instr=%h fault=%b fpc=%h addr=%h, want all zero",
                     out_valid, out_pc, out_instr, fault, fault_pc, imem_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        tick();
        for (int i = 0; i < 6; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp || out_instr !== word_at(exp)) begin
                failures++;
                $display("FAIL stream[%0d]: got valid=%b pc=%h instr=%h, want valid=1 pc=%h instr=%h",
                         i, out_valid, out_pc, out_instr, exp, word_at(exp));
            end
            tick();
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        do_reset();
        repeat (5) tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0000_0013 || imem_addr !== 32'h8) begin
            failures++;
            $display("FAIL stall_hold: got valid=%b pc=%h instr=%h addr=%h, want 1 0 00000013 8",
                     out_valid, out_pc, out_instr, imem_addr);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp || out_instr !== word_at(exp)) begin
                failures++;
                $display("FAIL stall_drain[%0d]: got valid=%b pc=%h instr=%h, want valid=1 pc=%h",
                         i, out_valid, out_pc, out_instr, exp);
            end
            tick();
        end
    endtask

    task automatic test_redirect_flush();
        out_ready = 1'b0;
        do_reset();
        repeat (2) tick();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        out_ready = 1'b1;
        exp = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== exp) begin
            failures++;
            $display("FAIL flush_consume: got valid=%b pc=%h, want valid=1 pc=%h", out_valid, out_pc, exp);
        end
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || imem_addr !== 32'h40) begin
            failures++;
            $display("FAIL flush_empty: got valid=%b pc=%h addr=%h, want valid=0 pc=0 addr=40",
                     out_valid, out_pc, imem_addr);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp || out_instr !== word_at(exp)) begin
                failures++;
                $display("FAIL flush_target[%0d]: got valid=%b pc=%h instr=%h, want pc=%h",
                         i, out_valid, out_pc, out_instr, exp);
            end
            tick();
        end
    endtask

    task automatic test_misaligned();
        out_ready = 1'b1;
        exp_q.delete();
        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (fault !== 1'b1 || fault_pc !== 32'h42 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL misalign_fault: got fault=%b fpc=%h valid=%b, want 1 42 0", fault, fault_pc, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || imem_addr !== 32'h42 || fault !== 1'b1) begin
                failures++;
                $display("FAIL misalign_frozen[%0d]: got valid=%b addr=%h fault=%b, want 0 42 1",
                         i, out_valid, imem_addr, fault);
            end
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (fault !== 1'b0 || fault_pc !== 32'h42 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL fault_exit: got fault=%b fpc=%h valid=%b, want 0 42 0", fault, fault_pc, out_valid);
        end
        exp_q.push_back(32'h80);
        exp_q.push_back(32'h84);
        tick();
        for (int i = 0; i < 2; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp || out_instr !== word_at(exp)) begin
                failures++;
                $display("FAIL after_fault[%0d]: got valid=%b pc=%h instr=%h, want pc=%h",
                         i, out_valid, out_pc, out_instr, exp);
            end
            tick();
        end
    endtask

    task automatic test_range();
        out_ready = 1'b1;
        exp_q.delete();
        redirect_valid = 1'b1;
        redirect_pc = 32'h3F8;
        tick();
        redirect_valid = 1'b0;
        exp_q.push_back(32'h3F8);
        exp_q.push_back(32'h3FC);
        tick();
        for (int i = 0; i < 2; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp || fault !== 1'b0) begin
                failures++;
                $display("FAIL range_tail[%0d]: got valid=%b pc=%h fault=%b, want 1 %h 0",
                         i, out_valid, out_pc, fault, exp);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || fault !== 1'b1 || fault_pc !== 32'h400) begin
            failures++;
            $display("FAIL range_fault: got valid=%b fault=%b fpc=%h, want 0 1 400", out_valid, fault, fault_pc);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || imem_addr !== 32'h400) begin
                failures++;
                $display("FAIL range_frozen[%0d]: got valid=%b addr=%h, want 0 400", i, out_valid, imem_addr);
            end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        do_reset();
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b1 || imem_addr === 32'h0) begin
            failures++;
            $display("FAIL pre_async: got valid=%b addr=%h, want valid=1 addr!=0", out_valid, imem_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h0 || out_pc !== 32'h0 || fault !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got valid=%b addr=%h pc=%h fault=%b, want 0 0 0 0",
                     out_valid, imem_addr, out_pc, fault);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            failures++;
            $display("FAIL post_async: got valid=%b pc=%h, want 1 0", out_valid, out_pc);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_flush();
        test_misaligned();
        test_range();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch initiator for the single-core RV32I pipeline. It owns the PC and drives the combinational instruction memory address. Each returned word is captured with its PC into a 2-entry fetch queue, which feeds decode over a valid/ready handshake. It also handles control-flow redirects and flushes, and raises a sticky fault on a misaligned or out-of-range fetch.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
IMEM_BYTES, 1024, instruction memory size in bytes; a fetch PC >= IMEM_BYTES is a range fault.
QUEUE_DEPTH, 2, fetch queue entries; fixed at 2, no other value supported.

Ports:
clk  input  1  rising-edge clock, single clock domain
rst_n  input  1  asynchronous active-low reset
imem_addr  output  32  byte address to instruction memory; always equals pc_q
imem_instr  input  32  instruction word returned combinationally for imem_addr
out_valid  output  1  queue head valid towards decode
out_ready  input  1  decode accepts head
out_pc  output  32  PC of head entry
out_instr  output  32  instruction of head entry
redirect_valid  input  1  branch/jump/trap redirect request, single-cycle pulse
redirect_pc  input  32  redirect target byte address
fault  output  1  sticky fetch fault
fault_pc  output  32  address that caused the fault

Behaviour:
- Reset (async assert, sync release):
  - pc_q=RESET_VECTOR, queue empty, state=FETCH.
  - out_valid=0, out_pc=0, out_instr=0, fault=0, fault_pc=0.
- States:
  - FETCH: normal operation.
  - FAULT: no pushes; pc_q frozen.
- Push condition (FETCH, no redirect):
  - Condition: count<2, or count==2 with a pop in the same cycle.
  - Push writes {pc_q, imem_instr}; pc_q <= pc_q+4.
- Pop: out_valid && out_ready.
  - Head advances; out_* show the next entry in the same cycle it becomes head.
  - out_* hold stable while out_valid && !out_ready.
- Latency and throughput:
  - First out_valid is asserted 1 cycle after reset release, with out_pc=RESET_VECTOR.
  - Sustained throughput is 1 instruction/cycle when out_ready stays high.
- Full with no pop: no push, pc_q holds.
- Empty: out_valid=0; out_pc/out_instr hold their last values.
- Redirect (highest priority, any state):
  - A pop in the same cycle still completes; that instruction is consumed.
  - All remaining entries are flushed (count=0); there is no push that cycle.
  - pc_q <= redirect_pc, and out_valid=0 next cycle.
- Redirect alignment check:
  - redirect_pc[1:0]!=0: state->FAULT, fault=1, fault_pc=redirect_pc.
  - Aligned redirect: state->FETCH, fault=0.
- Range fault (FETCH, no redirect):
  - Trigger: pc_q >= IMEM_BYTES.
  - No push; state->FAULT, fault=1, fault_pc=pc_q.
  - Entries already queued still drain normally.
- FAULT exit: only an aligned redirect or reset; it clears fault, while fault_pc keeps its last value.
- Arithmetic: pc increment is 32-bit modulo; wrap is unreachable because the range fault fires first.
- Reset mid-operation: immediate return to the reset values above, in-flight entries lost.

Decomposition:
- riscv_pkg additions:
  - fetch_entry_t packed struct {logic [31:0] pc; logic [31:0] instr;}.
  - fetch_state_e {FETCH, FAULT}.
  - IMEM_BYTES_DEFAULT constant (1024).
- Sub-module fetch_queue:
  - 2-entry FIFO of fetch_entry_t with push, pop, flush, full, empty and head.
  - Flush has priority over push; pop is honoured in the flush cycle.
- ifetch_unit holds the PC, state machine and fault logic.

Test Plan:
1. Reset release, out_ready=1, imem holds 0x00000013 at 0x0 and 0x00100093 at 0x4 -> out_pc 0x0 then 0x4 on consecutive cycles, one instruction per cycle.
2. out_ready=0 for 5 cycles after reset -> queue fills with PCs 0x0 and 0x4, imem_addr stalls at 0x8, out_pc holds 0x0; out_ready=1 -> 0x0, 0x4, 0x8 delivered with no gap.
3. Queue full (0x0, 0x4); in one cycle assert redirect_valid with redirect_pc=0x40 and out_ready=1 -> 0x0 consumed, 0x4 dropped, out_valid=0 next cycle, then out_pc=0x40.
4. Redirect to 0x42 -> fault=1, fault_pc=0x42, out_valid stays 0; then redirect to 0x80 -> fault=0, out_pc=0x80 delivered.
5. Redirect to 0x3F8 with out_ready=1 -> 0x3F8 and 0x3FC delivered, then fault=1, fault_pc=0x400, no further out_valid.
6. Assert rst_n=0 asynchronously mid-stream -> out_valid=0 and imem_addr=RESET_VECTOR immediately, without waiting for a clock edge.
